exu_alu_iter: RTL and testbench
===============================

Name: exu_alu_iter

Overview:
- Parametrised, multi-cycle successor to the EXU ALU path.
- Accepts operands and a function code over a valid/ready handshake.
- Single-cycle logic/arith/shift/compare ops complete in 1 cycle; MUL/MULHU/DIVU/REMU run iteratively (shift-add / restoring divide), one bit per cycle.
- Sits between EXU operand selection and writeback; the stall controller uses `busy`.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 8.
- FUNC_WIDTH, 4, width of alu_func.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from alu_b.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands/function valid
- in_ready  out  1  block can accept (high only in IDLE)
- alu_a  in  XLEN  operand A
- alu_b  in  XLEN  operand B
- alu_func  in  FUNC_WIDTH  function code
- out_valid  out  1  alu_result valid
- out_ready  in  1  consumer takes result
- alu_result  out  XLEN  registered result
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset: one clk edge with rst=1 forces state=IDLE, out_valid=0, alu_result=0, iteration counter=0, internal regs=0. Reset mid-CALC or in DONE aborts; the pending result is discarded.
- Function codes:
  - 0 NO_FUNC→0
  - 1 ADD, 2 SUB (mod 2^XLEN)
  - 3 XOR, 4 OR, 5 AND
  - 6 SLL, 7 SRL, 8 SRA (shift = alu_b[SHAMT_W-1:0])
  - 9 SLT (signed) / 10 SLTU → {0…,1 bit}
  - 11 MUL (low XLEN of product), 12 MULHU (high XLEN of unsigned product)
  - 13 DIVU, 14 REMU
  - 15 reserved→0
- States: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid, latch alu_a/alu_b/alu_func.
    - Codes 11–14 → CALC, counter=0.
    - Other codes → DONE, with the result computed from the inputs and registered on that edge.
  - CALC: one iteration per cycle; counter increments. At counter=XLEN-1 the final value is registered → DONE.
  - DONE: out_valid=1; alu_result held stable. On out_ready → IDLE. No new acceptance in DONE.
- Latency, counting the acceptance edge as cycle 0:
  - Simple ops: out_valid first high in cycle 1.
  - Iterative ops: out_valid first high in cycle XLEN+1, fixed and data-independent.
- Minimum throughput: one op per 2 cycles (simple) or XLEN+2 cycles (iterative).
- Inputs are ignored while in_ready=0. Operand changes after acceptance do not affect the result.
- MUL/MULHU: full 2·XLEN-bit unsigned product.
- Divide by zero (no trap, same latency): DIVU→all ones; REMU→alu_a.
- DIVU with alu_a < alu_b: quotient 0, remainder alu_a.
- out_ready high outside DONE has no effect.
- in_valid and out_ready high together in DONE: only the output handshake completes; the input is accepted next cycle in IDLE.
- out_valid never pulses without a prior acceptance; exactly one out_valid/out_ready handshake per accepted op.

Test Plan:
- ADD 0xFFFFFFFF+0x1 → alu_result 0x00000000, out_valid in cycle 1. SUB 0x0−0x1 → 0xFFFFFFFF.
- SRA 0x80000000 by alu_b=0x24 (shamt 4) → 0xF8000000. SRL same → 0x08000000. SLT 0xFFFFFFFF,0x1 → 1; SLTU → 0.
- MUL 0x12345678×0x10 → 0x23456780. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. For both, out_valid first high exactly 33 cycles after acceptance; in_ready=0 and busy=1 throughout.
- DIVU 100/7 → 14, REMU → 2. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. DIVU 3/9 → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → alu_result unchanged, out_valid=1, in_ready=0, and in_valid pulses ignored. Then raise out_ready → in_ready=1 the next cycle.
- Assert rst during CALC cycle 10 of a DIVU → next cycle state IDLE, out_valid=0, alu_result=0, in_ready=1. A following ADD 2+3 → 5 in cycle 1.

Source files
------------

// File: rtl/exu_alu_iter.sv
// Multi-cycle EXU ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring divide, one bit per cycle.
module exu_alu_iter #(
    parameter int XLEN       = 32,
    parameter int FUNC_WIDTH = 4,
    parameter int SHAMT_W    = $clog2(XLEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_a,
    input  logic [XLEN-1:0]       alu_b,
    input  logic [FUNC_WIDTH-1:0] alu_func,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       alu_result,
    output logic                  busy
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [FUNC_WIDTH-1:0] F_ADD   = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] F_SUB   = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] F_XOR   = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] F_OR    = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] F_AND   = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] F_SLL   = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] F_SRL   = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] F_SRA   = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] F_SLT   = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] F_SLTU  = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] F_MUL   = FUNC_WIDTH'(11);
    localparam logic [FUNC_WIDTH-1:0] F_MULHU = FUNC_WIDTH'(12);
    localparam logic [FUNC_WIDTH-1:0] F_DIVU  = FUNC_WIDTH'(13);
    localparam logic [FUNC_WIDTH-1:0] F_REMU  = FUNC_WIDTH'(14);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FUNC_WIDTH-1:0] func_q, func_d;
    logic [XLEN-1:0]       op_q, op_d;    // multiplicand or divisor
    logic [XLEN-1:0]       hi_q, hi_d;    // product high half or partial remainder
    logic [XLEN-1:0]       lo_q, lo_d;    // multiplier/product low half or dividend/quotient
    logic [XLEN-1:0]       res_q, res_d;

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    simple_res;
    logic               is_iter, is_mul_in, is_mul_q;
    logic [XLEN:0]      mul_sum;
    logic [XLEN-1:0]    mul_hi, mul_lo;
    logic [XLEN:0]      div_tmp;
    logic               div_ge;
    logic [XLEN-1:0]    div_diff, div_rem, div_quo;

    assign shamt     = alu_b[SHAMT_W-1:0];
    assign is_iter   = (alu_func >= F_MUL) && (alu_func <= F_REMU);
    assign is_mul_in = (alu_func == F_MUL) || (alu_func == F_MULHU);
    assign is_mul_q  = (func_q == F_MUL) || (func_q == F_MULHU);

    always_comb begin
        simple_res = '0;
        case (alu_func)
            F_ADD:   simple_res = alu_a + alu_b;
            F_SUB:   simple_res = alu_a - alu_b;
            F_XOR:   simple_res = alu_a ^ alu_b;
            F_OR:    simple_res = alu_a | alu_b;
            F_AND:   simple_res = alu_a & alu_b;
            F_SLL:   simple_res = alu_a << shamt;
            F_SRL:   simple_res = alu_a >> shamt;
            F_SRA:   simple_res = $unsigned($signed(alu_a) >>> shamt);
            F_SLT:   simple_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            F_SLTU:  simple_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            default: simple_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift the pair right.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    // Restoring step; a zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
    assign div_tmp  = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = div_tmp >= {1'b0, op_q};
    assign div_diff = div_tmp[XLEN-1:0] - op_q;
    assign div_rem  = div_ge ? div_diff : div_tmp[XLEN-1:0];
    assign div_quo  = {lo_q[XLEN-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    func_d = alu_func;
                    if (is_iter) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        hi_d    = '0;
                        op_d    = is_mul_in ? alu_a : alu_b;
                        lo_d    = is_mul_in ? alu_b : alu_a;
                    end else begin
                        state_d = S_DONE;
                        res_d   = simple_res;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                hi_d  = is_mul_q ? mul_hi : div_rem;
                lo_d  = is_mul_q ? mul_lo : div_quo;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    case (func_q)
                        F_MUL:   res_d = mul_lo;
                        F_MULHU: res_d = mul_hi;
                        F_DIVU:  res_d = div_quo;
                        default: res_d = div_rem;
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign alu_result = res_q;
endmodule

// File: tb/tb_exu_alu_iter.sv
// Directed-vector bench for exu_alu_iter with hand-computed expectations.
module tb_exu_alu_iter;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_func;
    int          n_vec, n_err;

    exu_alu_iter #(.XLEN(32), .FUNC_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency from the acceptance edge, check result and return to IDLE.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        bit stall_ok;
        int exp_lat;
        exp_lat  = (f >= 4'd11 && f <= 4'd14) ? 33 : 1;
        stall_ok = 1'b1;
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_func = f; alu_a = a; alu_b = b;
        tick();
        in_valid = 1'b0; alu_a = 32'hDEAD_BEEF; alu_b = 32'h0BAD_F00D; alu_func = 4'd1;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            if (in_ready || !busy) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_res"}, alu_result, exp);
        if (exp_lat > 1) chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ret"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_a = '0; alu_b = '0; alu_func = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        chk("rst_res", alu_result, 32'd0);

        run_op("add_wrap", 4'd1,  32'hFFFF_FFFF, 32'h1, 32'h0);
        run_op("sub_wrap", 4'd2,  32'h0, 32'h1, 32'hFFFF_FFFF);
        run_op("xor",      4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_op("or",       4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        run_op("and",      4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        run_op("sll31",    4'd6,  32'h1, 32'h3F, 32'h8000_0000);
        run_op("sra",      4'd8,  32'h8000_0000, 32'h24, 32'hF800_0000);
        run_op("srl",      4'd7,  32'h8000_0000, 32'h24, 32'h0800_0000);
        run_op("slt",      4'd9,  32'hFFFF_FFFF, 32'h1, 32'h1);
        run_op("sltu",     4'd10, 32'hFFFF_FFFF, 32'h1, 32'h0);
        run_op("nofunc",   4'd0,  32'h1234, 32'h5678, 32'h0);
        run_op("resv",     4'd15, 32'h1234, 32'h5678, 32'h0);
        run_op("mul",      4'd11, 32'h1234_5678, 32'h10, 32'h2345_6780);
        run_op("mulhu",    4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_lo_ff",4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("divu",     4'd13, 32'd100, 32'd7, 32'd14);
        run_op("remu",     4'd14, 32'd100, 32'd7, 32'd2);
        run_op("divu_z",   4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_z",   4'd14, 32'd5, 32'd0, 32'd5);
        run_op("divu_lt",  4'd13, 32'd3, 32'd9, 32'd0);
        run_op("remu_lt",  4'd14, 32'd3, 32'd9, 32'd3);

        // Backpressure: result must hold and new requests must be ignored in DONE.
        in_valid = 1'b1; alu_func = 4'd1; alu_a = 32'd2; alu_b = 32'd3;
        tick();
        alu_func = 4'd2; alu_a = 32'd100; alu_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            chk("bp_hold", {alu_result[28:0], out_valid, in_ready, busy}, {29'd5, 3'b101});
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
        tick();
        chk("bp_no_ghost", {29'd0, out_valid, in_ready, busy}, 32'b010);

        // out_ready outside DONE is inert.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("oready_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);

        // in_valid with out_ready in DONE: only the output handshake completes.
        in_valid = 1'b1; alu_func = 4'd1; alu_a = 32'd1; alu_b = 32'd1;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("both_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
        tick();
        in_valid = 1'b0;
        chk("both_accept", {alu_result[28:0], out_valid, in_ready, busy}, {29'd2, 3'b101});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during CALC cycle 10 of a DIVU aborts it.
        in_valid = 1'b1; alu_func = 4'd13; alu_a = 32'd100; alu_b = 32'd7;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("calc_busy", {29'd0, out_valid, in_ready, busy}, 32'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        chk("midrst_res", alu_result, 32'd0);
        run_op("add_after_rst", 4'd1, 32'd2, 32'd3, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
